// File: rtl/riscv_pkg.sv
// Shared RISC-V decode types and constants for the ALU issue controller.
// Holds the decoded-instruction record, issue FSM states and operand-use predicates.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [6:0] OPCODE_REG_REG = 7'b0110011;
  localparam logic [6:0] OPCODE_REG_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_LOAD    = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE   = 7'b0100011;
  localparam logic [6:0] OPCODE_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPCODE_JALR    = 7'b1100111;
  localparam logic [6:0] OPCODE_JAL     = 7'b1101111;
  localparam logic [6:0] OPCODE_LUI     = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC   = 7'b0010111;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_LW      = 3'b010;
  localparam logic [6:0] F7_ADD     = 7'b0000000;
  localparam logic [6:0] F7_SUB     = 7'b0100000;

  typedef struct packed {
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] reg_A;
    logic [XLEN-1:0] reg_B;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
  } decoded_instr_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } issue_state_e;

  function automatic logic uses_rs1(input logic [6:0] opcode);
    case (opcode)
      OPCODE_REG_REG, OPCODE_REG_IMM, OPCODE_LOAD,
      OPCODE_STORE, OPCODE_BRANCH, OPCODE_JALR: uses_rs1 = 1'b1;
      default:                                  uses_rs1 = 1'b0;
    endcase
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opcode);
    case (opcode)
      OPCODE_REG_REG, OPCODE_STORE, OPCODE_BRANCH: uses_rs2 = 1'b1;
      default:                                     uses_rs2 = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/operand_fwd_mux.sv
// Priority operand forwarding for one source register: EX/MEM beats MEM/WB beats buffer.
// x0 is never forwarded.
module operand_fwd_mux #(
  parameter int unsigned N = 32
) (
  input  logic [4:0]   rs,
  input  logic [N-1:0] buf_data,
  input  logic         ex_valid,
  input  logic [4:0]   ex_rd,
  input  logic [N-1:0] ex_data,
  input  logic         mem_valid,
  input  logic [4:0]   mem_rd,
  input  logic [N-1:0] mem_data,
  output logic [N-1:0] data
);

  always_comb begin
    data = buf_data;
    if (rs != 5'd0) begin
      if (ex_valid && (ex_rd == rs)) begin
        data = ex_data;
      end else if (mem_valid && (mem_rd == rs)) begin
        data = mem_data;
      end
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Decode-to-ALU issue controller: two-entry skid buffer, load-use bubble, operand forwarding.
// Optional performance counters are compiled in with ALU_ISSUE_PERF_EN.
module alu_issue_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned N     = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  decoded_instr_t in_instr,
  output logic           out_valid,
  input  logic           out_ready,
  output decoded_instr_t out_instr,
  input  logic           ex_fwd_valid,
  input  logic [4:0]     ex_fwd_rd,
  input  logic [N-1:0]   ex_fwd_data,
  input  logic           mem_fwd_valid,
  input  logic [4:0]     mem_fwd_rd,
  input  logic [N-1:0]   mem_fwd_data,
  input  logic           flush
`ifdef ALU_ISSUE_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] issue_cnt
`endif
);

  issue_state_e   state_q, state_d;
  decoded_instr_t head_q, head_d;
  decoded_instr_t skid_q, skid_d;
  logic           lu_valid_q, lu_valid_d;
  logic [4:0]     lu_rd_q, lu_rd_d;

  logic push, pop, hazard;
  logic haz_rs1, haz_rs2;
  logic [N-1:0] fwd_a, fwd_b;

  // lu_valid only ever holds a non-zero rd, so x0 cannot match here.
  assign haz_rs1 = uses_rs1(head_q.opcode) && (head_q.rs1 != 5'd0) && (head_q.rs1 == lu_rd_q);
  assign haz_rs2 = uses_rs2(head_q.opcode) && (head_q.rs2 != 5'd0) && (head_q.rs2 == lu_rd_q);
  assign hazard  = lu_valid_q && (haz_rs1 || haz_rs2);

  assign in_ready  = (state_q != TWO) && !flush && !rst;
  assign out_valid = (state_q != EMPTY) && !hazard && !flush;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  operand_fwd_mux #(.N(N)) u_fwd_rs1 (
    .rs        (head_q.rs1),
    .buf_data  (head_q.reg_A),
    .ex_valid  (ex_fwd_valid),
    .ex_rd     (ex_fwd_rd),
    .ex_data   (ex_fwd_data),
    .mem_valid (mem_fwd_valid),
    .mem_rd    (mem_fwd_rd),
    .mem_data  (mem_fwd_data),
    .data      (fwd_a)
  );

  operand_fwd_mux #(.N(N)) u_fwd_rs2 (
    .rs        (head_q.rs2),
    .buf_data  (head_q.reg_B),
    .ex_valid  (ex_fwd_valid),
    .ex_rd     (ex_fwd_rd),
    .ex_data   (ex_fwd_data),
    .mem_valid (mem_fwd_valid),
    .mem_rd    (mem_fwd_rd),
    .mem_data  (mem_fwd_data),
    .data      (fwd_b)
  );

  always_comb begin
    out_instr       = head_q;
    out_instr.reg_A = fwd_a;
    out_instr.reg_B = fwd_b;
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            state_d = ONE;
            head_d  = in_instr;
          end
        end
        ONE: begin
          if (push && !pop) begin
            state_d = TWO;
            skid_d  = in_instr;
          end else if (pop && !push) begin
            state_d = EMPTY;
          end else if (push && pop) begin
            head_d = in_instr;
          end
        end
        TWO: begin
          if (pop) begin
            state_d = ONE;
            head_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // The tracker only advances when execute accepts, so a held load keeps its hazard window.
  always_comb begin
    lu_valid_d = lu_valid_q;
    lu_rd_d    = lu_rd_q;
    if (flush) begin
      lu_valid_d = 1'b0;
    end else if (out_ready) begin
      lu_valid_d = pop && (head_q.opcode == OPCODE_LOAD) && (head_q.rd != 5'd0);
      lu_rd_d    = head_q.rd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      head_q     <= '0;
      skid_q     <= '0;
      lu_valid_q <= 1'b0;
      lu_rd_q    <= '0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      skid_q     <= skid_d;
      lu_valid_q <= lu_valid_d;
      lu_rd_q    <= lu_rd_d;
    end
  end

`ifdef ALU_ISSUE_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, issue_cnt_q;
  logic             stall_evt;

  assign stall_evt = (state_q != EMPTY) && hazard && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      issue_cnt_q <= '0;
    end else begin
      if (stall_evt && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      if (pop && (issue_cnt_q != {CNT_W{1'b1}})) begin
        issue_cnt_q <= issue_cnt_q + 1'b1;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign issue_cnt = issue_cnt_q;
`else
  logic unused_cnt_w;
  assign unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: stimulus queues expected issues, a monitor checks pops.
// Perf counter checks are included when ALU_ISSUE_PERF_EN is defined.
module tb_alu_issue_ctrl;
  import riscv_pkg::*;

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  decoded_instr_t in_instr;
  logic           out_valid;
  logic           out_ready;
  decoded_instr_t out_instr;
  logic           ex_fwd_valid;
  logic [4:0]     ex_fwd_rd;
  logic [31:0]    ex_fwd_data;
  logic           mem_fwd_valid;
  logic [4:0]     mem_fwd_rd;
  logic [31:0]    mem_fwd_data;
  logic           flush;
`ifdef ALU_ISSUE_PERF_EN
  logic [31:0]    stall_cnt;
  logic [31:0]    issue_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  decoded_instr_t exp_q[$];

  alu_issue_ctrl #(.N(32), .CNT_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_instr      (in_instr),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .ex_fwd_valid  (ex_fwd_valid),
    .ex_fwd_rd     (ex_fwd_rd),
    .ex_fwd_data   (ex_fwd_data),
    .mem_fwd_valid (mem_fwd_valid),
    .mem_fwd_rd    (mem_fwd_rd),
    .mem_fwd_data  (mem_fwd_data),
    .flush         (flush)
`ifdef ALU_ISSUE_PERF_EN
    ,
    .stall_cnt     (stall_cnt),
    .issue_cnt     (issue_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic decoded_instr_t mk(input logic [6:0] op, input logic [6:0] f7,
                                        input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] pc);
    decoded_instr_t d;
    d        = '0;
    d.opcode = op;
    d.funct3 = (op == OPCODE_LOAD) ? F3_LW : F3_ADD_SUB;
    d.funct7 = f7;
    d.rd     = rd;
    d.rs1    = rs1;
    d.rs2    = rs2;
    d.reg_A  = a;
    d.reg_B  = b;
    d.pc     = pc;
    return d;
  endfunction

  // Monitor: every accepted issue must match the next queued expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_issue: got pc %0h expected no issue", out_instr.pc);
      end else begin
        decoded_instr_t e;
        e = exp_q.pop_front();
        check("issue_instr", 256'(out_instr), 256'(e));
      end
    end
  end

  // LOAD lrd then ADD x6,lrd,x1 back to back; a bubble is expected only for lrd != x0.
  task automatic load_use(input logic [4:0] lrd, input logic [31:0] pc);
    decoded_instr_t ld, ad;
    ld = mk(OPCODE_LOAD, F7_ADD, lrd, 5'd1, 5'd0, 32'h10, 32'h0, pc);
    ad = mk(OPCODE_REG_REG, F7_ADD, 5'd6, lrd, 5'd1, 32'h77, 32'h10, pc + 32'd4);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_instr  = ld;
    exp_q.push_back(ld);
    tick();
    in_instr = ad;
    exp_q.push_back(ad);
    #1 check("lu_load_valid", 256'(out_valid), 256'(1'b1));
    tick();
    in_valid = 1'b0;
    #1 check("lu_bubble", 256'(out_valid), 256'(lrd == 5'd0));
    if (lrd != 5'd0) begin
      tick();
      #1 check("lu_after_bubble", 256'(out_valid), 256'(1'b1));
    end
    tick();
    #1 check("lu_drained", 256'(out_valid), 256'(1'b0));
  endtask

  initial begin
    decoded_instr_t add_i, sub_i, s1, s2, f1, f1_exp, z, g1, g2, g3;
    rst           = 1'b1;
    in_valid      = 1'b0;
    in_instr      = '0;
    out_ready     = 1'b0;
    flush         = 1'b0;
    ex_fwd_valid  = 1'b0;
    ex_fwd_rd     = '0;
    ex_fwd_data   = '0;
    mem_fwd_valid = 1'b0;
    mem_fwd_rd    = '0;
    mem_fwd_data  = '0;

    tick();
    tick();
    check("rst_in_ready", 256'(in_ready), 256'(1'b0));
    check("rst_out_valid", 256'(out_valid), 256'(1'b0));
    check("rst_out_instr", 256'(out_instr), 256'(0));
    rst = 1'b0;
    #1 check("post_rst_in_ready", 256'(in_ready), 256'(1'b1));

    // Back-to-back flow
    add_i = mk(OPCODE_REG_REG, F7_ADD, 5'd3, 5'd1, 5'd2, 32'h11, 32'h22, 32'h100);
    sub_i = mk(OPCODE_REG_REG, F7_SUB, 5'd4, 5'd1, 5'd2, 32'h11, 32'h22, 32'h104);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_instr  = add_i;
    exp_q.push_back(add_i);
    tick();
    in_instr = sub_i;
    exp_q.push_back(sub_i);
    #1 check("b2b_valid_add", 256'(out_valid), 256'(1'b1));
    check("b2b_ready_add", 256'(in_ready), 256'(1'b1));
    tick();
    in_valid = 1'b0;
    #1 check("b2b_valid_sub", 256'(out_valid), 256'(1'b1));
    check("b2b_ready_sub", 256'(in_ready), 256'(1'b1));
    tick();
    #1 check("b2b_empty", 256'(out_valid), 256'(1'b0));

    // Skid: fill two entries while execute is stalled
    s1 = mk(OPCODE_REG_IMM, F7_ADD, 5'd10, 5'd11, 5'd0, 32'h200, 32'h0, 32'h200);
    s2 = mk(OPCODE_REG_REG, F7_ADD, 5'd12, 5'd13, 5'd14, 32'h201, 32'h202, 32'h204);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = s1;
    exp_q.push_back(s1);
    tick();
    in_instr = s2;
    exp_q.push_back(s2);
    #1 check("skid_ready_one", 256'(in_ready), 256'(1'b1));
    tick();
    in_valid = 1'b0;
    #1 check("skid_ready_two", 256'(in_ready), 256'(1'b0));
    check("skid_valid_two", 256'(out_valid), 256'(1'b1));
    tick();
    #1 check("skid_head_stable", 256'(out_instr), 256'(s1));
    out_ready = 1'b1;
    #1 check("skid_ready_indep", 256'(in_ready), 256'(1'b0));
    tick();
    #1 check("skid_ready_back", 256'(in_ready), 256'(1'b1));
    check("skid_second_valid", 256'(out_valid), 256'(1'b1));
    tick();
    #1 check("skid_empty", 256'(out_valid), 256'(1'b0));

    // Load-use, then the same with rd = x0
    load_use(5'd5, 32'h300);
    load_use(5'd0, 32'h320);

    // Forwarding priority, inspected while the head is held
    f1 = mk(OPCODE_REG_REG, F7_ADD, 5'd9, 5'd7, 5'd8, 32'h1111, 32'h2222, 32'h400);
    ex_fwd_valid  = 1'b1;
    ex_fwd_rd     = 5'd7;
    ex_fwd_data   = 32'hAAAA_0001;
    mem_fwd_valid = 1'b1;
    mem_fwd_rd    = 5'd7;
    mem_fwd_data  = 32'h5555_0002;
    out_ready     = 1'b0;
    in_valid      = 1'b1;
    in_instr      = f1;
    tick();
    in_valid = 1'b0;
    #1 check("fwd_ex_prio", 256'(out_instr.reg_A), 256'(32'hAAAA_0001));
    check("fwd_b_buffered", 256'(out_instr.reg_B), 256'(32'h2222));
    ex_fwd_valid = 1'b0;
    #1 check("fwd_mem_only", 256'(out_instr.reg_A), 256'(32'h5555_0002));
    ex_fwd_valid = 1'b1;
    ex_fwd_rd    = 5'd8;
    ex_fwd_data  = 32'h0000_0BBB;
    #1 check("fwd_ex_b", 256'(out_instr.reg_B), 256'(32'h0000_0BBB));
    check("fwd_mem_a", 256'(out_instr.reg_A), 256'(32'h5555_0002));
    f1_exp       = f1;
    f1_exp.reg_A = 32'h5555_0002;
    f1_exp.reg_B = 32'h0000_0BBB;
    exp_q.push_back(f1_exp);
    out_ready = 1'b1;
    tick();

    z = mk(OPCODE_REG_REG, F7_ADD, 5'd10, 5'd0, 5'd0, 32'h33, 32'h44, 32'h404);
    ex_fwd_rd     = 5'd0;
    ex_fwd_data   = 32'hFFFF;
    mem_fwd_rd    = 5'd0;
    mem_fwd_data  = 32'hEEEE;
    in_valid      = 1'b1;
    in_instr      = z;
    exp_q.push_back(z);
    tick();
    in_valid = 1'b0;
    #1 check("fwd_x0_a", 256'(out_instr.reg_A), 256'(32'h33));
    check("fwd_x0_b", 256'(out_instr.reg_B), 256'(32'h44));
    tick();
    ex_fwd_valid  = 1'b0;
    mem_fwd_valid = 1'b0;
    #1 check("fwd_drained", 256'(out_valid), 256'(1'b0));

    // Flush from TWO with a concurrent incoming instruction; none of these may issue
    g1 = mk(OPCODE_REG_REG, F7_ADD, 5'd20, 5'd21, 5'd22, 32'h1, 32'h2, 32'h500);
    g2 = mk(OPCODE_REG_REG, F7_ADD, 5'd23, 5'd24, 5'd25, 32'h3, 32'h4, 32'h504);
    g3 = mk(OPCODE_REG_REG, F7_ADD, 5'd26, 5'd27, 5'd28, 32'h5, 32'h6, 32'h508);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = g1;
    tick();
    in_instr = g2;
    tick();
    #1 check("flush_pre_two", 256'(in_ready), 256'(1'b0));
    flush    = 1'b1;
    in_instr = g3;
    #1 check("flush_in_ready", 256'(in_ready), 256'(1'b0));
    check("flush_out_valid", 256'(out_valid), 256'(1'b0));
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    #1 check("flush_empty_valid", 256'(out_valid), 256'(1'b0));
    check("flush_empty_ready", 256'(in_ready), 256'(1'b1));
    out_ready = 1'b1;
    tick();
    #1 check("flush_no_issue", 256'(out_valid), 256'(1'b0));

`ifdef ALU_ISSUE_PERF_EN
    rst = 1'b1;
    tick();
    check("perf_rst_stall", 256'(stall_cnt), 256'(0));
    check("perf_rst_issue", 256'(issue_cnt), 256'(0));
    rst = 1'b0;
    load_use(5'd5, 32'h600);
    load_use(5'd6, 32'h610);
    load_use(5'd7, 32'h620);
    check("perf_stall_cnt", 256'(stall_cnt), 256'(3));
    check("perf_issue_cnt", 256'(issue_cnt), 256'(6));
`endif

    tick();
    check("scoreboard_drained", 256'(exp_q.size()), 256'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
